// File: rtl/uc_if.sv
// Control-unit <-> datapath bundle.
// master is the control unit, slave is the datapath side.
interface uc_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic             zero;
  logic             carry;
  logic             s_skip;
  logic             s_inc;
  logic             s_inm;
  logic             we;
  logic [2:0]       ALUOp;
  logic             flag_z;
  logic             flag_c;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  Opcode, zero, carry,
    output s_skip, s_inc, s_inm, we, ALUOp,
    output flag_z, flag_c, halted, illegal, instret
  );

  modport slave (
    output Opcode, zero, carry,
    input  s_skip, s_inc, s_inm, we, ALUOp,
    input  flag_z, flag_c, halted, illegal, instret
  );
endinterface

// File: rtl/uc.sv
// Control unit of the 8-bit single-cycle micro-controller:
// combinational opcode decode plus flags, run/halt and instret state.
module uc #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  uc_if.master bus
);
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  logic             fz;
  logic             fc;
  logic             ill;
  logic [CNT_W-1:0] cnt;

  logic [5:0] op;
  logic c_alu, c_li, c_jmp, c_jz, c_jnz, c_jc;
  logic c_skz, c_skc, c_nop, c_hlt, c_ill;

  logic       we_d;
  logic       inm_d;
  logic       inc_d;
  logic       skip_d;
  logic [2:0] alu_d;

  assign op = bus.Opcode;

  // Every 6-bit encoding falls into exactly one class.
  always_comb begin
    c_alu = 1'b0;
    c_li  = 1'b0;
    c_jmp = 1'b0;
    c_jz  = 1'b0;
    c_jnz = 1'b0;
    c_jc  = 1'b0;
    c_skz = 1'b0;
    c_skc = 1'b0;
    c_nop = 1'b0;
    c_hlt = 1'b0;
    c_ill = 1'b0;
    unique case (1'b1)
      op[5]:                c_alu = 1'b1;
      op[5:4] == 2'b01:     c_ill = 1'b1;
      op[5:2] == 4'b0011:   c_ill = 1'b1;
      op[5:2] == 4'b0001:   c_li  = 1'b1;
      op == 6'b000000:      c_jmp = 1'b1;
      op == 6'b000001:      c_jz  = 1'b1;
      op == 6'b000010:      c_jnz = 1'b1;
      op == 6'b000011:      c_jc  = 1'b1;
      op == 6'b001000:      c_skz = 1'b1;
      op == 6'b001001:      c_skc = 1'b1;
      op == 6'b001010:      c_nop = 1'b1;
      op == 6'b001011:      c_hlt = 1'b1;
      default:              c_nop = 1'b1;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    inm_d  = 1'b0;
    inc_d  = 1'b1;
    skip_d = 1'b0;
    alu_d  = 3'b000;
    if (state == HALT) begin
      inc_d = 1'b0;
    end else begin
      unique case (1'b1)
        c_alu: begin
          we_d  = 1'b1;
          alu_d = op[4:2];
        end
        c_li: begin
          we_d  = 1'b1;
          inm_d = 1'b1;
        end
        c_jmp: inc_d  = 1'b0;
        c_jz:  inc_d  = ~fz;
        c_jnz: inc_d  = fz;
        c_jc:  inc_d  = ~fc;
        c_skz: skip_d = fz;
        c_skc: skip_d = fc;
        c_hlt: inc_d  = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      fz    <= 1'b0;
      fc    <= 1'b0;
      ill   <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (c_alu) begin
        fz <= bus.zero;
        fc <= bus.carry;
      end
      if (c_ill)
        ill <= 1'b1;
      if (c_hlt)
        state <= HALT;
    end
  end

  assign bus.we      = we_d & reset;
  assign bus.s_inm   = inm_d;
  assign bus.s_inc   = inc_d;
  assign bus.s_skip  = skip_d;
  assign bus.ALUOp   = alu_d;
  assign bus.flag_z  = fz;
  assign bus.flag_c  = fc;
  assign bus.halted  = (state == HALT);
  assign bus.illegal = ill;
  assign bus.instret = cnt;
endmodule

// File: tb/tb_uc.sv
// Bench for uc: decode vector table, halt/reset sequences,
// randomized run against a rule-level model, CNT_W=4 saturation.
module tb_uc;
  logic clk;
  logic rst;
  logic rst4;

  uc_if #(.CNT_W(16)) b();
  uc_if #(.CNT_W(4))  b4();

  uc #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (b.master)
  );

  uc #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (b4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       c;
    logic       we;
    logic       inm;
    logic       inc;
    logic       skip;
    logic [2:0] alu;
    logic       fz;
    logic       fc;
    logic       ill;
  } vec_t;

  vec_t tbl[18];

  // rule-level reference state
  bit mz, mc, mh, mi;
  int mcnt;

  task automatic model_reset();
    mz = 0; mc = 0; mh = 0; mi = 0; mcnt = 0;
  endtask

  task automatic model_out(input int o, input bit rn,
                           output bit we, output bit inm,
                           output bit inc, output bit skip,
                           output bit [2:0] alu);
    we = 0; inm = 0; inc = 1; skip = 0; alu = 0;
    if (mh) inc = 0;
    else if (o >= 32) begin
      we = 1;
      alu = 3'((o / 4) % 8);
    end
    else if (o >= 4 && o <= 7) begin
      we = 1;
      inm = 1;
    end
    else if (o == 0 || o == 11) inc = 0;
    else if (o == 1) inc = !mz;
    else if (o == 2) inc = mz;
    else if (o == 3) inc = !mc;
    else if (o == 8) skip = mz;
    else if (o == 9) skip = mc;
    if (!rn) we = 0;
  endtask

  task automatic model_edge(input int o, input bit z, input bit c);
    if (mh) return;
    if (mcnt < 65535) mcnt++;
    if (o >= 32) begin
      mz = z;
      mc = c;
    end
    if (o >= 12 && o < 32) mi = 1;
    if (o == 11) mh = 1;
  endtask

  initial begin
    bit we, inm, inc, skip;
    bit [2:0] alu;
    int o, hcyc;
    bit z, c, dr;

    n_chk = 0;
    n_fail = 0;

    tbl[0]  = '{6'b100100, 1, 0, 1, 0, 1, 0, 3'b001, 1, 0, 0};
    tbl[1]  = '{6'b000001, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0};
    tbl[2]  = '{6'b000010, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 0};
    tbl[3]  = '{6'b001000, 0, 0, 0, 0, 1, 1, 3'b000, 1, 0, 0};
    tbl[4]  = '{6'b001001, 0, 1, 0, 0, 1, 0, 3'b000, 1, 0, 0};
    tbl[5]  = '{6'b000011, 0, 0, 0, 0, 1, 0, 3'b000, 1, 0, 0};
    tbl[6]  = '{6'b111100, 0, 1, 1, 0, 1, 0, 3'b111, 0, 1, 0};
    tbl[7]  = '{6'b000011, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0};
    tbl[8]  = '{6'b000001, 1, 0, 0, 0, 1, 0, 3'b000, 0, 1, 0};
    tbl[9]  = '{6'b001000, 1, 1, 0, 0, 1, 0, 3'b000, 0, 1, 0};
    tbl[10] = '{6'b000111, 1, 0, 1, 1, 1, 0, 3'b000, 0, 1, 0};
    tbl[11] = '{6'b000000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0};
    tbl[12] = '{6'b001010, 0, 0, 0, 0, 1, 0, 3'b000, 0, 1, 0};
    tbl[13] = '{6'b101011, 1, 1, 1, 0, 1, 0, 3'b010, 1, 1, 0};
    tbl[14] = '{6'b000100, 0, 0, 1, 1, 1, 0, 3'b000, 1, 1, 0};
    tbl[15] = '{6'b010000, 0, 0, 0, 0, 1, 0, 3'b000, 1, 1, 1};
    tbl[16] = '{6'b001010, 0, 0, 0, 0, 1, 0, 3'b000, 1, 1, 1};
    tbl[17] = '{6'b001100, 0, 0, 0, 0, 1, 0, 3'b000, 1, 1, 1};

    rst = 1'b0;
    rst4 = 1'b0;
    b.Opcode = 6'b100100;
    b.zero = 1'b1;
    b.carry = 1'b1;
    b4.Opcode = 6'b001010;
    b4.zero = 1'b0;
    b4.carry = 1'b0;

    // reset state, we forced low while decode still shows ALUOp
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", b.we, 0);
    chk("rst_aluop", b.ALUOp, 3'b001);
    chk("rst_state", {b.flag_z, b.flag_c, b.halted, b.illegal}, 0);
    chk("rst_cnt", b.instret, 0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      b.Opcode = tbl[i].op;
      b.zero = tbl[i].z;
      b.carry = tbl[i].c;
      #2;
      chk($sformatf("tbl%0d_ctl", i),
          {b.we, b.s_inm, b.s_inc, b.s_skip, b.ALUOp},
          {tbl[i].we, tbl[i].inm, tbl[i].inc, tbl[i].skip, tbl[i].alu});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_st", i),
          {b.flag_z, b.flag_c, b.illegal},
          {tbl[i].fz, tbl[i].fc, tbl[i].ill});
      chk($sformatf("tbl%0d_cnt", i), b.instret, i + 1);
    end

    // HALT and frozen state
    @(negedge clk);
    b.Opcode = 6'b001011;
    #2;
    chk("halt_ctl", {b.we, b.s_inc, b.halted}, 3'b000);
    @(posedge clk);
    #1;
    chk("halt_st", {b.halted, b.we, b.instret}, {1'b1, 1'b0, 16'd19});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b.Opcode = 6'b111111;
      b.zero = 1'b0;
      b.carry = 1'b0;
      #2;
      chk("halted_ctl",
          {b.we, b.s_inm, b.s_inc, b.s_skip, b.ALUOp}, 7'b0);
      @(posedge clk);
      #1;
      chk("halted_frz",
          {b.flag_z, b.flag_c, b.halted, b.instret},
          {3'b111, 16'd19});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("halt_rst",
        {b.halted, b.illegal, b.flag_z, b.flag_c, b.instret}, 0);
    rst = 1'b1;
    b.Opcode = 6'b000001;
    #1;
    chk("post_rst_jz", b.s_inc, 1);
    @(posedge clk);
    #1;
    chk("post_rst_cnt", b.instret, 1);

    // randomized run against the rule-level model
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
    hcyc = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      o = $urandom_range(0, 63);
      if ($urandom_range(0, 19) == 0) o = 11;
      z = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 39) == 0) || (mh && hcyc > 4);
      b.Opcode = 6'(o);
      b.zero = z;
      b.carry = c;
      rst = !dr;
      #1;
      if (dr) begin
        model_reset();
        hcyc = 0;
      end
      #1;
      model_out(o, !dr, we, inm, inc, skip, alu);
      chk("rnd_ctl",
          {b.we, b.s_inm, b.s_inc, b.s_skip, b.ALUOp},
          {we, inm, inc, skip, alu});
      @(posedge clk);
      #1;
      if (!dr) model_edge(o, z, c);
      if (mh) hcyc++;
      chk("rnd_st",
          {b.flag_z, b.flag_c, b.halted, b.illegal},
          {mz, mc, mh, mi});
      chk("rnd_cnt", b.instret, mcnt);
      rst = 1'b1;
    end

    // CNT_W=4 saturation and asynchronous mid-cycle reset
    @(negedge clk);
    rst4 = 1'b1;
    b4.Opcode = 6'b100000;
    b4.zero = 1'b1;
    b4.carry = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_alu", {b4.flag_z, b4.flag_c, b4.instret}, {2'b11, 4'd1});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      b4.Opcode = 6'b001010;
      @(posedge clk);
      #1;
      chk("sat_cnt", b4.instret, (i + 2 > 15) ? 15 : i + 2);
    end
    #2;
    rst4 = 1'b0;
    #1;
    chk("async_rst", {b4.flag_z, b4.flag_c, b4.instret}, 0);
    @(negedge clk);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    chk("async_resume", {b4.halted, b4.instret}, {1'b0, 4'd1});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
